// File: rtl/vga_overlay_ctrl.sv
// rtl/vga_overlay_ctrl.sv - score/falling-block overlay update sequencer with frame-aligned commit
module vga_overlay_ctrl #(
    parameter int unsigned ITER      = 14,
    parameter int unsigned SAT_MAX   = 9999,
    parameter logic [9:0]  OFFSCREEN = 10'h3FF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] score_in,
    input  logic [79:0] blk_pos_in,
    input  logic [23:0] blk_color_in,
    input  logic        frame_start,
    output logic [3:0]  dig_thousands,
    output logic [3:0]  dig_hundreds,
    output logic [3:0]  dig_tens,
    output logic [3:0]  dig_ones,
    output logic [79:0] blk_pos_out,
    output logic [23:0] blk_color_out,
    output logic        sat,
    output logic        commit,
    output logic        busy
);
    localparam int unsigned CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_PENDING} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ITER-1:0] bin_q, bin_d;
    logic [15:0]     bcd_q, bcd_d, bcd_adj;
    logic [79:0]     cap_pos_q, cap_pos_d;
    logic [23:0]     cap_color_q, cap_color_d;
    logic            cap_sat_q, cap_sat_d;
    logic [15:0]     dig_q, dig_d;
    logic [79:0]     pos_q, pos_d;
    logic [23:0]     color_q, color_d;
    logic            sat_q, sat_d;
    logic            commit_q, commit_d;
    logic            over;

    assign over = (score_in > SAT_MAX);

    // Double-dabble correction: nibbles of 5 or more would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cap_pos_d   = cap_pos_q;
        cap_color_d = cap_color_q;
        cap_sat_d   = cap_sat_q;
        dig_d       = dig_q;
        pos_d       = pos_q;
        color_d     = color_q;
        sat_d       = sat_q;
        commit_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cap_pos_d   = blk_pos_in;
                    cap_color_d = blk_color_in;
                    cap_sat_d   = over;
                    bin_d       = over ? ITER'(SAT_MAX) : score_in[ITER-1:0];
                    bcd_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d = (bcd_adj << 1) | {15'd0, bin_q[ITER-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (frame_start) begin
                    dig_d    = bcd_q;
                    pos_d    = cap_pos_q;
                    color_d  = cap_color_q;
                    sat_d    = cap_sat_q;
                    commit_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cap_pos_q   <= '0;
            cap_color_q <= '0;
            cap_sat_q   <= 1'b0;
            dig_q       <= '0;
            pos_q       <= {8{OFFSCREEN}};
            color_q     <= '0;
            sat_q       <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cap_pos_q   <= cap_pos_d;
            cap_color_q <= cap_color_d;
            cap_sat_q   <= cap_sat_d;
            dig_q       <= dig_d;
            pos_q       <= pos_d;
            color_q     <= color_d;
            sat_q       <= sat_d;
            commit_q    <= commit_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign dig_thousands = dig_q[15:12];
    assign dig_hundreds  = dig_q[11:8];
    assign dig_tens      = dig_q[7:4];
    assign dig_ones      = dig_q[3:0];
    assign blk_pos_out   = pos_q;
    assign blk_color_out = color_q;
    assign sat           = sat_q;
    assign commit        = commit_q;
endmodule

// File: tb/tb_vga_overlay_ctrl.sv
// tb/tb_vga_overlay_ctrl.sv - randomized self-checking bench for vga_overlay_ctrl
module tb_vga_overlay_ctrl;
    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] score_in = '0;
    logic [79:0] blk_pos_in = '0;
    logic [23:0] blk_color_in = '0;
    logic        in_ready, sat, commit, busy;
    logic [3:0]  d3, d2, d1, d0;
    logic [79:0] blk_pos_out;
    logic [23:0] blk_color_out;
    logic [120:0] out_vec;
    logic [120:0] model_q;
    logic [79:0]  p7, p8;
    int checks = 0;
    int errors = 0;

    localparam logic [120:0] RESET_VEC = {16'h0, {8{10'h3FF}}, 24'h0, 1'b0};

    vga_overlay_ctrl dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .score_in(score_in), .blk_pos_in(blk_pos_in), .blk_color_in(blk_color_in),
        .frame_start(frame_start), .dig_thousands(d3), .dig_hundreds(d2),
        .dig_tens(d1), .dig_ones(d0), .blk_pos_out(blk_pos_out),
        .blk_color_out(blk_color_out), .sat(sat), .commit(commit), .busy(busy)
    );

    assign out_vec = {d3, d2, d1, d0, blk_pos_out, blk_color_out, sat};

    always #5 clock = ~clock;

    function automatic logic [120:0] expect_vec(input logic [31:0] s, input logic [79:0] p,
                                                input logic [23:0] c);
        logic [31:0] v;
        logic        clamp;
        clamp = (s > 32'd9999);
        v = clamp ? 32'd9999 : s;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), p, c, clamp};
    endfunction

    function automatic logic [79:0] rand_pos();
        logic [79:0] p;
        for (int i = 0; i < 8; i++) p[10*i +: 10] = 10'($urandom_range(0, 1023));
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at the negedge after the accept edge T0; returns at the negedge after the commit edge.
    task automatic wait_commit(input int fs_at, input bit early, input logic [120:0] exp_new);
        for (int t = 1; t < fs_at; t++) begin
            frame_start = early && (t == 5 || t == 10);
            @(posedge clock);
            @(negedge clock);
            frame_start = 1'b0;
            check("busy", busy, 1);
            check("ready_low", in_ready, 0);
            check("no_commit", commit, 0);
            check("hold", out_vec, model_q);
        end
        frame_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0;
        model_q = exp_new;
        check("commit", commit, 1);
        check("outputs", out_vec, model_q);
        check("busy_clr", busy, 0);
        check("ready_back", in_ready, 1);
    endtask

    task automatic run_update(input logic [31:0] s, input logic [79:0] p, input logic [23:0] c,
                              input int fs_at, input bit early);
        @(negedge clock);
        check("ready_idle", in_ready, 1);
        in_valid = 1'b1;
        score_in = s;
        blk_pos_in = p;
        blk_color_in = c;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        score_in = $urandom;
        blk_pos_in = rand_pos();
        blk_color_in = 24'($urandom);
        wait_commit(fs_at, early, expect_vec(s, p, c));
        @(negedge clock);
        check("commit_pulse", commit, 0);
        check("stable", out_vec, model_q);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            frame_start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            frame_start = 1'b0;
            check("idle_commit", commit, 0);
            check("idle_busy", busy, 0);
            check("idle_hold", out_vec, model_q);
        end
    endtask

    initial begin
        logic [31:0] s;
        model_q = RESET_VEC;
        #2 resetn = 1'b0;
        #10;
        check("rst_out", out_vec, RESET_VEC);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_commit", commit, 0);
        @(negedge clock);
        resetn = 1'b1;

        run_update(32'd1234, {8{10'd40}}, 24'hFF0000, 20, 1'b0);
        run_update(32'd12345, rand_pos(), 24'h123456, 16, 1'b0);
        run_update(32'h8000_0005, rand_pos(), 24'hABCDEF, 15, 1'b0);
        run_update(32'd0, rand_pos(), 24'h00FFFF, 40, 1'b1);
        run_update(32'd9999, rand_pos(), 24'h010203, 15, 1'b0);
        run_update(32'd10000, rand_pos(), 24'h040506, 17, 1'b0);

        // Producer keeps in_valid high; the second update waits for the first commit.
        p7 = rand_pos();
        p8 = rand_pos();
        @(negedge clock);
        check("b2b_ready", in_ready, 1);
        in_valid = 1'b1;
        score_in = 32'd7;
        blk_pos_in = p7;
        blk_color_in = 24'h00FF00;
        @(posedge clock);
        @(negedge clock);
        score_in = 32'd8;
        blk_pos_in = p8;
        blk_color_in = 24'h0000FF;
        wait_commit(16, 1'b0, expect_vec(32'd7, p7, 24'h00FF00));
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        check("b2b_accept", busy, 1);
        check("b2b_nocommit", commit, 0);
        check("b2b_hold", out_vec, model_q);
        wait_commit(20, 1'b0, expect_vec(32'd8, p8, 24'h0000FF));
        @(negedge clock);
        check("b2b_pulse", commit, 0);

        idle_frames(3);

        // Reset in the middle of a conversion drops the pending update.
        run_update(32'd42, rand_pos(), 24'h424242, 18, 1'b0);
        @(negedge clock);
        in_valid = 1'b1;
        score_in = 32'd777;
        blk_pos_in = rand_pos();
        blk_color_in = 24'h777777;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("pre_rst_busy", busy, 1);
        resetn = 1'b0;
        #1;
        model_q = RESET_VEC;
        check("mid_rst_out", out_vec, model_q);
        check("mid_rst_commit", commit, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clock);
        resetn = 1'b1;
        check("post_rst_ready", in_ready, 1);
        idle_frames(3);

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: s = $urandom_range(0, 9999);
                1: s = $urandom_range(9990, 10010);
                2: s = $urandom;
                default: s = $urandom_range(0, 99);
            endcase
            run_update(s, rand_pos(), 24'($urandom), int'($urandom_range(15, 24)),
                       1'($urandom_range(0, 1)));
        end
        idle_frames(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
